// File: rtl/cellrv32_mtime_fetch.sv
// rtl/cellrv32_mtime_fetch.sv - coherent 64-bit mtime snapshot reader and glitch-free mtimecmp writer on the IO bus
module cellrv32_mtime_fetch #(
  parameter logic [31:0] MTIME_BASE = 32'hFFFFFF40,
  parameter int unsigned TIMEOUT    = 15,
  parameter int unsigned MAX_RETRY  = 3
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        rd_req_i,
  input  logic        cmp_wr_req_i,
  input  logic [63:0] cmp_data_i,
  output logic        busy_o,
  output logic        done_o,
  output logic        err_o,
  output logic [63:0] time_o,
  output logic        time_valid_o,
  output logic [31:0] bus_addr_o,
  output logic        bus_rden_o,
  output logic        bus_wren_o,
  output logic [31:0] bus_data_o,
  input  logic [31:0] bus_data_i,
  input  logic        bus_ack_i
);

  // one step per bus access; wait_q selects ISSUE (0) or WAIT (1) within the step
  typedef enum logic [2:0] {
    S_IDLE, S_RD_HI1, S_RD_LO, S_RD_HI2, S_WR_LO1, S_WR_HI, S_WR_LO2
  } step_e;

  localparam logic [7:0]  TMO_LAST     = 8'(TIMEOUT - 1);
  localparam logic [3:0]  RETRY_LIM    = 4'(MAX_RETRY);
  localparam logic [31:0] ADDR_TIME_LO = MTIME_BASE;
  localparam logic [31:0] ADDR_TIME_HI = MTIME_BASE + 32'h4;
  localparam logic [31:0] ADDR_CMP_LO  = MTIME_BASE + 32'h8;
  localparam logic [31:0] ADDR_CMP_HI  = MTIME_BASE + 32'hC;

  step_e       step_q, step_d;
  logic        wait_q, wait_d;
  logic [7:0]  tcnt_q, tcnt_d;
  logic [3:0]  retry_q, retry_d;
  logic        pend_rd_q, pend_rd_d;
  logic        pend_wr_q, pend_wr_d;
  logic [63:0] hold_q, hold_d;
  logic [63:0] work_q, work_d;
  logic [31:0] hi1_q, hi1_d;
  logic [31:0] lo_q, lo_d;
  logic [63:0] time_q, time_d;
  logic        valid_q, valid_d;
  logic        done_q, done_d;
  logic        err_q, err_d;
  logic [31:0] addr_q, addr_d;
  logic        rden_q, rden_d;
  logic        wren_q, wren_d;
  logic [31:0] wdata_q, wdata_d;

  // state and datapath registers, synchronous reset clears everything
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      step_q    <= S_IDLE;
      wait_q    <= 1'b0;
      tcnt_q    <= 8'h0;
      retry_q   <= 4'h0;
      pend_rd_q <= 1'b0;
      pend_wr_q <= 1'b0;
      hold_q    <= 64'h0;
      work_q    <= 64'h0;
      hi1_q     <= 32'h0;
      lo_q      <= 32'h0;
      time_q    <= 64'h0;
      valid_q   <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      addr_q    <= 32'h0;
      rden_q    <= 1'b0;
      wren_q    <= 1'b0;
      wdata_q   <= 32'h0;
    end else begin
      step_q    <= step_d;
      wait_q    <= wait_d;
      tcnt_q    <= tcnt_d;
      retry_q   <= retry_d;
      pend_rd_q <= pend_rd_d;
      pend_wr_q <= pend_wr_d;
      hold_q    <= hold_d;
      work_q    <= work_d;
      hi1_q     <= hi1_d;
      lo_q      <= lo_d;
      time_q    <= time_d;
      valid_q   <= valid_d;
      done_q    <= done_d;
      err_q     <= err_d;
      addr_q    <= addr_d;
      rden_q    <= rden_d;
      wren_q    <= wren_d;
      wdata_q   <= wdata_d;
    end
  end

  // sequencing: arbitration, access phases, timeout, hi-word coherence check
  always_comb begin
    step_d    = step_q;
    wait_d    = wait_q;
    tcnt_d    = tcnt_q;
    retry_d   = retry_q;
    pend_rd_d = pend_rd_q | rd_req_i;
    pend_wr_d = pend_wr_q | cmp_wr_req_i;
    hold_d    = cmp_wr_req_i ? cmp_data_i : hold_q;
    work_d    = work_q;
    hi1_d     = hi1_q;
    lo_d      = lo_q;
    time_d    = time_q;
    valid_d   = valid_q;
    done_d    = 1'b0;
    err_d     = 1'b0;
    if (step_q == S_IDLE) begin
      wait_d = 1'b0;
      // pending flag is consumed on start so a request arriving mid-sequence runs again afterwards;
      // the write works from its own copy so a later request cannot tear the in-flight value
      if (pend_wr_d) begin
        step_d    = S_WR_LO1;
        pend_wr_d = 1'b0;
        work_d    = hold_d;
      end else if (pend_rd_d) begin
        step_d    = S_RD_HI1;
        pend_rd_d = 1'b0;
        retry_d   = 4'h0;
      end
    end else if (!wait_q) begin
      wait_d = 1'b1;
      tcnt_d = 8'h0;
    end else if (bus_ack_i) begin
      wait_d = 1'b0;
      case (step_q)
        S_RD_HI1: begin
          hi1_d  = bus_data_i;
          step_d = S_RD_LO;
        end
        S_RD_LO: begin
          lo_d   = bus_data_i;
          step_d = S_RD_HI2;
        end
        S_RD_HI2: begin
          if (bus_data_i == hi1_q) begin
            time_d  = {hi1_q, lo_q};
            valid_d = 1'b1;
            done_d  = 1'b1;
            step_d  = S_IDLE;
          end else if (retry_q == RETRY_LIM) begin
            done_d = 1'b1;
            err_d  = 1'b1;
            step_d = S_IDLE;
          end else begin
            // lo carried into the hi word between reads: re-read lo against the newer hi
            retry_d = retry_q + 4'd1;
            hi1_d   = bus_data_i;
            step_d  = S_RD_LO;
          end
        end
        S_WR_LO1: step_d = S_WR_HI;
        S_WR_HI:  step_d = S_WR_LO2;
        S_WR_LO2: begin
          done_d = 1'b1;
          step_d = S_IDLE;
        end
        default:  step_d = S_IDLE;
      endcase
    end else if (tcnt_q == TMO_LAST) begin
      done_d = 1'b1;
      err_d  = 1'b1;
      step_d = S_IDLE;
      wait_d = 1'b0;
    end else begin
      tcnt_d = tcnt_q + 8'd1;
    end
  end

  // bus strobes for the upcoming cycle; lo is parked at all-ones first so mtimecmp never dips below target
  always_comb begin
    rden_d  = 1'b0;
    wren_d  = 1'b0;
    addr_d  = addr_q;
    wdata_d = 32'h0;
    if (!wait_d) begin
      case (step_d)
        S_RD_HI1, S_RD_HI2: begin
          rden_d = 1'b1;
          addr_d = ADDR_TIME_HI;
        end
        S_RD_LO: begin
          rden_d = 1'b1;
          addr_d = ADDR_TIME_LO;
        end
        S_WR_LO1: begin
          wren_d  = 1'b1;
          addr_d  = ADDR_CMP_LO;
          wdata_d = 32'hFFFFFFFF;
        end
        S_WR_HI: begin
          wren_d  = 1'b1;
          addr_d  = ADDR_CMP_HI;
          wdata_d = work_d[63:32];
        end
        S_WR_LO2: begin
          wren_d  = 1'b1;
          addr_d  = ADDR_CMP_LO;
          wdata_d = work_d[31:0];
        end
        default: ;
      endcase
    end
  end

  assign busy_o       = (step_q != S_IDLE) | pend_rd_q | pend_wr_q | done_q;
  assign done_o       = done_q;
  assign err_o        = err_q;
  assign time_o       = time_q;
  assign time_valid_o = valid_q;
  assign bus_addr_o   = addr_q;
  assign bus_rden_o   = rden_q;
  assign bus_wren_o   = wren_q;
  assign bus_data_o   = wdata_q;

endmodule

// File: tb/tb_cellrv32_mtime_fetch.sv
// tb/tb_cellrv32_mtime_fetch.sv - randomized self-checking bench for cellrv32_mtime_fetch
module tb_cellrv32_mtime_fetch;

  localparam logic [31:0] BASE = 32'hFFFFFF40;
  localparam int TMO  = 15;
  localparam int MAXR = 3;

  logic        clk = 1'b0;
  logic        rst_i = 1'b1;
  logic        rd_req_i = 1'b0;
  logic        cmp_wr_req_i = 1'b0;
  logic [63:0] cmp_data_i = 64'h0;
  logic        busy_o, done_o, err_o, time_valid_o;
  logic [63:0] time_o;
  logic [31:0] bus_addr_o, bus_data_o;
  logic        bus_rden_o, bus_wren_o;
  logic [31:0] bus_data_i = 32'h0;
  logic        bus_ack_i = 1'b0;

  cellrv32_mtime_fetch #(
    .MTIME_BASE(BASE), .TIMEOUT(TMO), .MAX_RETRY(MAXR)
  ) dut (
    .clk_i(clk), .rst_i(rst_i), .rd_req_i(rd_req_i), .cmp_wr_req_i(cmp_wr_req_i),
    .cmp_data_i(cmp_data_i), .busy_o(busy_o), .done_o(done_o), .err_o(err_o),
    .time_o(time_o), .time_valid_o(time_valid_o), .bus_addr_o(bus_addr_o),
    .bus_rden_o(bus_rden_o), .bus_wren_o(bus_wren_o), .bus_data_o(bus_data_o),
    .bus_data_i(bus_data_i), .bus_ack_i(bus_ack_i)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  // responder: records every strobe, acks lat cycles later (lat 0 = never)
  typedef struct {
    logic [31:0] addr;
    logic        we;
    logic [31:0] data;
    int          cyc;
  } acc_t;

  acc_t        log_q[$];
  logic [31:0] rd_script[$];
  logic [63:0] mt = 64'h0;
  logic [31:0] resp_word = 32'h0;
  int          lat = 1;
  int          rcnt = 0;
  int          dz_err = 0;

  always @(negedge clk) begin
    acc_t a;
    bus_ack_i = 1'b0;
    bus_data_i = 32'h0;
    if (rcnt > 0) begin
      rcnt--;
      if (rcnt == 0) begin
        bus_ack_i = 1'b1;
        bus_data_i = resp_word;
      end
    end
    if (!bus_wren_o && bus_data_o != 32'h0) dz_err++;
    if (bus_rden_o || bus_wren_o) begin
      a.addr = bus_addr_o;
      a.we   = bus_wren_o;
      a.data = bus_data_o;
      a.cyc  = cyc;
      log_q.push_back(a);
      if (bus_rden_o) begin
        if (rd_script.size() > 0) resp_word = rd_script.pop_front();
        else resp_word = (bus_addr_o == BASE + 32'h4) ? mt[63:32] : mt[31:0];
      end
      rcnt = lat;
    end
  end

  // reference: walk the responder's read words by the hi/lo/hi coherence rule
  function automatic void model_read(input logic [31:0] s [0:8], output logic ok,
                                     output logic [63:0] v, output int n);
    logic [31:0] hi;
    int r;
    hi = s[0];
    r = 0;
    ok = 1'b0;
    v = 64'h0;
    n = 1;
    for (int k = 0; k <= MAXR; k++) begin
      n += 2;
      if (s[2 + 2*k] == hi) begin
        ok = 1'b1;
        v = {hi, s[1 + 2*k]};
        return;
      end
      r++;
      if (r > MAXR) return;
      hi = s[2 + 2*k];
    end
  endfunction

  logic [63:0] m_time = 64'h0;
  logic        m_valid = 1'b0;

  task automatic pulse_req(input logic rd, input logic wr, input logic [63:0] d, output int t);
    @(negedge clk);
    rd_req_i = rd;
    cmp_wr_req_i = wr;
    cmp_data_i = d;
    t = cyc;
    @(negedge clk);
    rd_req_i = 1'b0;
    cmp_wr_req_i = 1'b0;
    cmp_data_i = {$urandom, $urandom};
  endtask

  task automatic wait_done(input int budget, output int dcyc, output logic derr);
    dcyc = -1;
    derr = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (done_o) begin
        dcyc = cyc;
        derr = err_o;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic run_read(input string tag, input int l, input int exp_n, input logic exp_err);
    int t, d;
    logic e;
    lat = l;
    log_q.delete();
    pulse_req(1'b1, 1'b0, 64'h0, t);
    wait_done(400, d, e);
    chk({tag, "_done_cyc"}, 64'(d), 64'(t + 1 + exp_n * (l + 1)));
    chk({tag, "_err"}, 64'(e), 64'(exp_err));
    chk({tag, "_time"}, time_o, m_time);
    chk({tag, "_valid"}, 64'(time_valid_o), 64'(m_valid));
    chk({tag, "_busy_done"}, 64'(busy_o), 64'd1);
    chk({tag, "_nacc"}, 64'(log_q.size()), 64'(exp_n));
    for (int i = 0; i < log_q.size(); i++)
      chk($sformatf("%s_addr%0d", tag, i), {31'h0, log_q[i].we, log_q[i].addr},
          {32'h0, BASE + ((i % 2 == 0) ? 32'h4 : 32'h0)});
    @(negedge clk);
    chk({tag, "_busy_after"}, 64'(busy_o), 64'd0);
    rd_script.delete();
  endtask

  task automatic run_write(input string tag, input int l, input logic [63:0] d);
    int t, dc;
    logic e;
    logic [31:0] ea [0:2];
    logic [31:0] ed [0:2];
    ea[0] = BASE + 32'h8; ed[0] = 32'hFFFFFFFF;
    ea[1] = BASE + 32'hC; ed[1] = d[63:32];
    ea[2] = BASE + 32'h8; ed[2] = d[31:0];
    lat = l;
    log_q.delete();
    pulse_req(1'b0, 1'b1, d, t);
    wait_done(400, dc, e);
    chk({tag, "_done_cyc"}, 64'(dc), 64'(t + 1 + 3 * (l + 1)));
    chk({tag, "_err"}, 64'(e), 64'd0);
    chk({tag, "_nacc"}, 64'(log_q.size()), 64'd3);
    for (int i = 0; i < 3; i++)
      if (i < log_q.size())
        chk($sformatf("%s_acc%0d", tag, i), {log_q[i].we, log_q[i].addr, log_q[i].data},
            {1'b1, ea[i], ed[i]});
    @(negedge clk);
    chk({tag, "_busy_after"}, 64'(busy_o), 64'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: still running at cycle %0d, limit 50000", cyc);
    $fatal(1);
  end

  initial begin
    int t, d1, d2, n;
    logic e, ok;
    logic [63:0] v, wd;
    logic [31:0] scr [0:8];

    // reset state
    repeat (3) @(negedge clk);
    chk("rst_busy", 64'(busy_o), 64'd0);
    chk("rst_done_err", {62'h0, done_o, err_o}, 64'd0);
    chk("rst_time", time_o, 64'h0);
    chk("rst_valid", 64'(time_valid_o), 64'd0);
    chk("rst_bus", {bus_rden_o, bus_wren_o, bus_addr_o, bus_data_o}, 64'h0);
    rst_i = 1'b0;
    repeat (2) @(negedge clk);

    // steady mtime read
    mt = 64'h00000001_00000010;
    m_time = mt; m_valid = 1'b1;
    run_read("rd_basic", 1, 3, 1'b0);

    // hi-word rollover between reads: one retry
    rd_script = '{32'h5, 32'h2, 32'h6, 32'h3, 32'h6};
    m_time = 64'h00000006_00000003;
    run_read("rd_roll", 1, 5, 1'b0);

    // every hi read differs: retries exhausted
    rd_script = '{32'h1, 32'h0, 32'h2, 32'h0, 32'h3, 32'h0, 32'h4, 32'h0, 32'h5};
    run_read("rd_exhaust", 1, 9, 1'b1);

    // compare write ordering
    run_write("wr_basic", 1, 64'h12345678_9ABCDEF0);

    // write and read requested together: write first, read strobe right after write done
    mt = 64'h0000ABCD_00001234;
    lat = 1;
    log_q.delete();
    pulse_req(1'b1, 1'b1, 64'hCAFEF00D_01020304, t);
    wait_done(100, d1, e);
    chk("both_wr_done", 64'(d1), 64'(t + 7));
    chk("both_wr_err", 64'(e), 64'd0);
    @(negedge clk);
    wait_done(100, d2, e);
    chk("both_rd_done", 64'(d2), 64'(d1 + 7));
    chk("both_rd_err", 64'(e), 64'd0);
    chk("both_time", time_o, mt);
    m_time = mt;
    chk("both_nacc", 64'(log_q.size()), 64'd6);
    if (log_q.size() == 6) begin
      chk("both_order", {60'h0, log_q[0].we, log_q[2].we, log_q[3].we, log_q[5].we}, 64'b1100);
      chk("both_rd_strobe", 64'(log_q[3].cyc), 64'(d1 + 1));
      chk("both_wr_hi", {32'h0, log_q[1].data}, 64'hCAFEF00D);
    end
    @(negedge clk);

    // no ack: single strobe, abort after TIMEOUT wait cycles
    lat = 0;
    log_q.delete();
    pulse_req(1'b1, 1'b0, 64'h0, t);
    wait_done(100, d1, e);
    chk("tmo_done", 64'(d1), 64'(t + 2 + TMO));
    chk("tmo_err", 64'(e), 64'd1);
    chk("tmo_time", time_o, m_time);
    chk("tmo_valid", 64'(time_valid_o), 64'(m_valid));
    repeat (3) @(negedge clk);
    chk("tmo_nacc", 64'(log_q.size()), 64'd1);
    chk("tmo_idle", 64'(busy_o), 64'd0);

    // reset while waiting on the lo read
    lat = 5;
    log_q.delete();
    pulse_req(1'b1, 1'b0, 64'h0, t);
    for (int i = 0; i < 50 && log_q.size() < 2; i++) @(negedge clk);
    chk("rmid_reach_lo", 64'(log_q.size()), 64'd2);
    @(negedge clk);
    rst_i = 1'b1;
    @(negedge clk);
    chk("rmid_bus", {bus_rden_o, bus_wren_o, bus_addr_o, bus_data_o}, 64'h0);
    chk("rmid_flags", {60'h0, busy_o, done_o, err_o, time_valid_o}, 64'h0);
    chk("rmid_time", time_o, 64'h0);
    rst_i = 1'b0;
    m_time = 64'h0;
    m_valid = 1'b0;
    n = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (done_o || busy_o) n++;
    end
    chk("rmid_quiet", 64'(n), 64'd0);
    chk("rmid_nacc", 64'(log_q.size()), 64'd2);
    mt = 64'h00000002_FFFFFFF0;
    m_time = mt; m_valid = 1'b1;
    run_read("rmid_rd", 1, 3, 1'b0);

    // randomized reads and writes with random ack latency
    for (int it = 0; it < 20; it++) begin
      if ($urandom_range(0, 2) != 0) begin
        scr[0] = $urandom;
        for (int k = 1; k < 9; k += 2) begin
          scr[k] = $urandom;
          scr[k+1] = ($urandom_range(0, 2) == 0) ? $urandom : scr[k-1];
        end
        for (int k = 0; k < 9; k++) rd_script.push_back(scr[k]);
        model_read(scr, ok, v, n);
        if (ok) begin
          m_time = v;
          m_valid = 1'b1;
        end
        run_read($sformatf("rnd%0d_rd", it), int'($urandom_range(1, 3)), n, !ok);
      end else begin
        wd = {$urandom, $urandom};
        run_write($sformatf("rnd%0d_wr", it), int'($urandom_range(1, 3)), wd);
      end
    end

    chk("bus_data_idle_zero", 64'(dz_err), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
